freq_sweep_ctrl: RTL and testbench

FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

---
 rtl/freq_ctrl_pkg.sv | 23 ++
 rtl/freq_settle_timer.sv | 33 +++
 rtl/freq_sweep_ctrl.sv | 177 +++++++++++++++++
 tb/tb_freq_sweep_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_ctrl_pkg.sv
// Shared types and default constants for the inverter frequency sweep controller.
package freq_ctrl_pkg;

   localparam int unsigned CLK_SYS_HZ        = 50_000_000;

   localparam int unsigned PERIOD_W_DEF      = 16;
   localparam int unsigned PERIOD_INIT_DEF   = 1250;
   localparam int unsigned PERIOD_MIN_DEF    = 1000;
   localparam int unsigned PERIOD_MAX_DEF    = 2000;
   localparam int unsigned STEP_INIT_DEF     = 64;
   localparam int unsigned STEP_MIN_DEF      = 1;
   localparam int unsigned SETTLE_CYCLES_DEF = 2500;
   localparam int unsigned MAX_STEPS_DEF     = 255;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      MEASURE = 3'd2,
      STEP    = 3'd3,
      LOCKED  = 3'd4
   } state_t;

endpackage

// File: rtl/freq_settle_timer.sv
// Blanking timer: down-counter reloaded by a one-cycle load pulse. With load
// registered alongside the FSM's entry into SETTLE, done rises so that SETTLE
// lasts exactly SETTLE_CYCLES cycles. SETTLE_CYCLES must be at least 2.
module freq_settle_timer
   import freq_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  logic clk,
   input  logic nrst,
   input  logic load,
   output logic done
);

   localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   // Reload on load, otherwise count down and park at zero.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_W'(SETTLE_CYCLES - 1);
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Masking with load stops a stale count from a cancelled settle firing early.
   assign done = (cnt == CNT_W'(1)) && !load;

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Resonant-frequency sweep controller: steps the inverter period toward the
// optimum reported by the measurement block, halving the step on reversals.
//
// state   | meaning
// IDLE    | no sweep; period held
// SETTLE  | blanking after a period change
// MEASURE | waiting for freq_ready / freq_opt
// STEP    | apply one period step (single cycle)
// LOCKED  | optimum found; period held
module freq_sweep_ctrl
   import freq_ctrl_pkg::*;
#(
   parameter int unsigned PERIOD_W      = PERIOD_W_DEF,
   parameter int unsigned PERIOD_INIT   = PERIOD_INIT_DEF,
   parameter int unsigned PERIOD_MIN    = PERIOD_MIN_DEF,
   parameter int unsigned PERIOD_MAX    = PERIOD_MAX_DEF,
   parameter int unsigned STEP_INIT     = STEP_INIT_DEF,
   parameter int unsigned STEP_MIN      = STEP_MIN_DEF,
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int unsigned MAX_STEPS     = MAX_STEPS_DEF
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                start,
   input  logic                abort,
   input  logic                freq_ready,
   input  logic                freq_set_up_down,
   input  logic                freq_opt,
   output logic [PERIOD_W-1:0] period,
   output logic                period_load,
   output logic                busy,
   output logic                locked,
   output logic                fail,
   output logic [7:0]          step_cnt
);

   localparam int unsigned INIT_CL = (PERIOD_INIT < PERIOD_MIN) ? PERIOD_MIN :
                                     (PERIOD_INIT > PERIOD_MAX) ? PERIOD_MAX : PERIOD_INIT;

   localparam logic [PERIOD_W-1:0] PERIOD_INIT_C = PERIOD_W'(INIT_CL);
   localparam logic [PERIOD_W-1:0] PERIOD_MIN_C  = PERIOD_W'(PERIOD_MIN);
   localparam logic [PERIOD_W-1:0] PERIOD_MAX_C  = PERIOD_W'(PERIOD_MAX);
   localparam logic [PERIOD_W-1:0] STEP_INIT_C   = PERIOD_W'(STEP_INIT);
   localparam logic [PERIOD_W-1:0] STEP_MIN_C    = PERIOD_W'(STEP_MIN);
   localparam logic [PERIOD_W:0]   MIN_X         = (PERIOD_W+1)'(PERIOD_MIN);
   localparam logic [PERIOD_W:0]   MAX_X         = (PERIOD_W+1)'(PERIOD_MAX);

   state_t              state;
   logic [PERIOD_W-1:0] step;
   logic                dir_last;
   logic                dir_req;
   logic                clamp_pend;
   logic                settle_load;
   logic                settle_done;

   logic                reversal;
   logic [PERIOD_W-1:0] halved;
   logic [PERIOD_W-1:0] step_eff;
   logic [PERIOD_W:0]   p_ext;
   logic [PERIOD_W:0]   s_ext;
   logic [PERIOD_W:0]   raw;
   logic [PERIOD_W-1:0] period_nxt;
   logic                clamp_hit;
   logic [7:0]          cnt_inc;
   logic                max_hit;

   freq_settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle (
      .clk  (clk),
      .nrst (nrst),
      .load (settle_load),
      .done (settle_done)
   );

   // Next step size and clamped period for the STEP state. A clamp on the
   // previous step forces a reversal so the step keeps shrinking at a limit.
   always_comb begin
      reversal   = (dir_req != dir_last) || clamp_pend;
      halved     = step >> 1;
      if (halved < STEP_MIN_C) begin
         halved = STEP_MIN_C;
      end
      step_eff   = (reversal && (step > STEP_MIN_C)) ? halved : step;
      p_ext      = {1'b0, period};
      s_ext      = {1'b0, step_eff};
      raw        = dir_req ? (p_ext - s_ext) : (p_ext + s_ext);
      clamp_hit  = 1'b0;
      period_nxt = raw[PERIOD_W-1:0];
      if (dir_req) begin
         if (raw[PERIOD_W] || (raw < MIN_X)) begin
            clamp_hit  = 1'b1;
            period_nxt = PERIOD_MIN_C;
         end
      end else if (raw > MAX_X) begin
         clamp_hit  = 1'b1;
         period_nxt = PERIOD_MAX_C;
      end
      cnt_inc    = (step_cnt == 8'hFF) ? 8'hFF : (step_cnt + 8'd1);
      max_hit    = ({24'd0, cnt_inc} >= MAX_STEPS);
   end

   // Sweep FSM with registered outputs; abort beats start beats state logic.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= IDLE;
         period      <= PERIOD_INIT_C;
         period_load <= 1'b0;
         busy        <= 1'b0;
         locked      <= 1'b0;
         fail        <= 1'b0;
         step_cnt    <= 8'd0;
         step        <= STEP_INIT_C;
         dir_last    <= 1'b1;
         dir_req     <= 1'b1;
         clamp_pend  <= 1'b0;
         settle_load <= 1'b0;
      end else begin
         period_load <= 1'b0;
         settle_load <= 1'b0;
         if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            locked <= 1'b0;
         end else if (start) begin
            state       <= SETTLE;
            period      <= PERIOD_INIT_C;
            period_load <= 1'b1;
            step        <= STEP_INIT_C;
            dir_last    <= 1'b1;
            clamp_pend  <= 1'b0;
            step_cnt    <= 8'd0;
            fail        <= 1'b0;
            busy        <= 1'b1;
            locked      <= 1'b0;
            settle_load <= 1'b1;
         end else begin
            case (state)
               SETTLE: begin
                  if (settle_done) begin
                     state <= MEASURE;
                  end
               end
               MEASURE: begin
                  if (freq_opt) begin
                     state  <= LOCKED;
                     busy   <= 1'b0;
                     locked <= 1'b1;
                  end else if (freq_ready) begin
                     state   <= STEP;
                     dir_req <= freq_set_up_down;
                  end
               end
               STEP: begin
                  period      <= period_nxt;
                  period_load <= 1'b1;
                  step        <= step_eff;
                  step_cnt    <= cnt_inc;
                  clamp_pend  <= clamp_hit;
                  dir_last    <= clamp_hit ? ~dir_req : dir_req;
                  if ((clamp_hit && (step_eff == STEP_MIN_C)) || max_hit) begin
                     fail  <= 1'b1;
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state       <= SETTLE;
                     settle_load <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed bench for freq_sweep_ctrl with default parameters.
module tb_freq_sweep_ctrl;
   import freq_ctrl_pkg::*;

   localparam int SETTLE_N = 2500;

   logic        clk;
   logic        nrst;
   logic        start;
   logic        abort;
   logic        freq_ready;
   logic        freq_set_up_down;
   logic        freq_opt;
   logic [15:0] period;
   logic        period_load;
   logic        busy;
   logic        locked;
   logic        fail;
   logic [7:0]  step_cnt;

   int checks = 0;
   int errors = 0;

   freq_sweep_ctrl dut (
      .clk              (clk),
      .nrst             (nrst),
      .start            (start),
      .abort            (abort),
      .freq_ready       (freq_ready),
      .freq_set_up_down (freq_set_up_down),
      .freq_opt         (freq_opt),
      .period           (period),
      .period_load      (period_load),
      .busy             (busy),
      .locked           (locked),
      .fail             (fail),
      .step_cnt         (step_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_measure();
      int n;
      n = 0;
      while ((dut.state != MEASURE) && (n < SETTLE_N + 10)) begin
         @(negedge clk);
         n++;
      end
      check_val("reach_measure", 32'(dut.state), 32'(MEASURE));
   endtask

   // Request one step from MEASURE and check the applied period.
   task automatic do_step(input logic dir, input int exp_p, input int exp_cnt);
      freq_set_up_down = dir;
      freq_ready       = 1'b1;
      @(negedge clk);
      freq_ready       = 1'b0;
      check_val("in_step", 32'(dut.state), 32'(STEP));
      @(negedge clk);
      check_val("step_period", 32'(period), 32'(exp_p));
      check_val("step_load", 32'(period_load), 32'd1);
      check_val("step_cnt", 32'(step_cnt), 32'(exp_cnt));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_period"}, 32'(period), 32'd1250);
      check_val({tag, "_load"}, 32'(period_load), 32'd0);
      check_val({tag, "_busy"}, 32'(busy), 32'd0);
      check_val({tag, "_locked"}, 32'(locked), 32'd0);
      check_val({tag, "_fail"}, 32'(fail), 32'd0);
      check_val({tag, "_cnt"}, 32'(step_cnt), 32'd0);
   endtask

   initial begin
      nrst             = 1'b0;
      start            = 1'b0;
      abort            = 1'b0;
      freq_ready       = 1'b0;
      freq_set_up_down = 1'b0;
      freq_opt         = 1'b0;
      tick(2);
      check_reset_outputs("rst");
      nrst = 1'b1;
      tick(2);

      // abort wins over a simultaneous start
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check_val("abort_prio_state", 32'(dut.state), 32'(IDLE));
      check_val("abort_prio_load", 32'(period_load), 32'd0);

      // start, settle length
      pulse_start();
      check_val("start_period", 32'(period), 32'd1250);
      check_val("start_load", 32'(period_load), 32'd1);
      check_val("start_busy", 32'(busy), 32'd1);
      tick(1);
      check_val("load_one_cycle", 32'(period_load), 32'd0);
      tick(SETTLE_N - 2);
      check_val("settle_last", 32'(dut.state), 32'(SETTLE));
      tick(1);
      check_val("settle_done", 32'(dut.state), 32'(MEASURE));
      check_val("measure_busy", 32'(busy), 32'd1);

      // three steps up, clamp at minimum, then bounce with halved step
      do_step(1'b1, 1186, 1); wait_measure();
      do_step(1'b1, 1122, 2); wait_measure();
      do_step(1'b1, 1058, 3); wait_measure();
      do_step(1'b1, 1000, 4); wait_measure();
      do_step(1'b0, 1032, 5); wait_measure();

      // restart from MEASURE, reversal halves step
      pulse_start();
      check_val("restart_period", 32'(period), 32'd1250);
      check_val("restart_cnt", 32'(step_cnt), 32'd0);
      wait_measure();
      do_step(1'b1, 1186, 1); wait_measure();
      do_step(1'b0, 1218, 2); wait_measure();

      // freq_opt beats freq_ready
      freq_opt         = 1'b1;
      freq_ready       = 1'b1;
      freq_set_up_down = 1'b1;
      @(negedge clk);
      freq_opt   = 1'b0;
      freq_ready = 1'b0;
      check_val("lock_locked", 32'(locked), 32'd1);
      check_val("lock_busy", 32'(busy), 32'd0);
      check_val("lock_period", 32'(period), 32'd1218);
      freq_ready = 1'b1;
      @(negedge clk);
      freq_ready = 1'b0;
      tick(3);
      check_val("locked_ignore_ready", 32'(period), 32'd1218);
      check_val("locked_hold", 32'(locked), 32'd1);

      // start from LOCKED, ready ignored during SETTLE, abort holds period
      pulse_start();
      check_val("relock_start_locked", 32'(locked), 32'd0);
      check_val("relock_start_period", 32'(period), 32'd1250);
      wait_measure();
      do_step(1'b1, 1186, 1);
      tick(10);
      freq_set_up_down = 1'b0;
      freq_ready       = 1'b1;
      @(negedge clk);
      freq_ready = 1'b0;
      tick(5);
      check_val("settle_ignore_period", 32'(period), 32'd1186);
      check_val("settle_ignore_state", 32'(dut.state), 32'(SETTLE));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("abort_state", 32'(dut.state), 32'(IDLE));
      check_val("abort_period", 32'(period), 32'd1186);
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_fail", 32'(fail), 32'd0);

      // reset asserted while in STEP
      pulse_start();
      wait_measure();
      freq_set_up_down = 1'b1;
      freq_ready       = 1'b1;
      @(negedge clk);
      freq_ready = 1'b0;
      check_val("pre_rst_step", 32'(dut.state), 32'(STEP));
      #1 nrst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      nrst = 1'b1;
      tick(3);
      check_reset_outputs("postrst");

      // drive into the lower clamp until the step hits minimum
      pulse_start();
      wait_measure();
      do_step(1'b1, 1186, 1); wait_measure();
      do_step(1'b1, 1122, 2); wait_measure();
      do_step(1'b1, 1058, 3); wait_measure();
      do_step(1'b1, 1000, 4); wait_measure();
      do_step(1'b1, 1000, 5); wait_measure();
      do_step(1'b1, 1000, 6); wait_measure();
      do_step(1'b1, 1000, 7); wait_measure();
      do_step(1'b1, 1000, 8); wait_measure();
      do_step(1'b1, 1000, 9);
      check_val("pre_fail_fail", 32'(fail), 32'd0);
      wait_measure();
      freq_set_up_down = 1'b1;
      freq_ready       = 1'b1;
      @(negedge clk);
      freq_ready = 1'b0;
      @(negedge clk);
      check_val("fail_flag", 32'(fail), 32'd1);
      check_val("fail_state", 32'(dut.state), 32'(IDLE));
      check_val("fail_busy", 32'(busy), 32'd0);
      check_val("fail_cnt", 32'(step_cnt), 32'd10);
      check_val("fail_period", 32'(period), 32'd1000);
      tick(3);
      check_val("fail_sticky", 32'(fail), 32'd1);
      pulse_start();
      check_val("fail_cleared", 32'(fail), 32'd0);
      check_val("fail_restart_period", 32'(period), 32'd1250);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
